// File: rtl/agn_wave_mtr.sv
// Multi-mode periodic waveform generator: one sample per ce tick, scaled by an amplitude code
// and saturated to the DAC width. Mode and gain are latched only at the start of a period.
module agn_wave_mtr #(
  parameter int unsigned NP     = 100,
  parameter int unsigned FS_MAX = 4000,
  parameter int unsigned OW     = 12,
  parameter int unsigned MW     = 8,
  parameter int unsigned MSH    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [1:0]    mode,
  input  logic [MW-1:0] M,
  output logic [OW-1:0] MTR,
  output logic          vld,
  output logic          sync,
  output logic          UP
);

  localparam int unsigned H     = NP / 2;
  localparam int unsigned SCALE = FS_MAX / H;
  localparam int unsigned PW    = $clog2(NP);
  localparam int unsigned BW    = $clog2(FS_MAX + 1);
  localparam int unsigned XW    = (BW + MW > OW) ? BW + MW : OW;

  localparam logic [PW-1:0] PhLast = PW'(NP - 1);
  localparam logic [PW-1:0] PhHalf = PW'(H);
  localparam logic [BW-1:0] ScaleB = BW'(SCALE);
  localparam logic [XW-1:0] Sat    = XW'((64'd1 << OW) - 64'd1);

  localparam logic [1:0] ModeTri    = 2'd0;
  localparam logic [1:0] ModeSawUp  = 2'd1;
  localparam logic [1:0] ModeSquare = 2'd2;

  logic [PW-1:0] ph_q, ph_d;
  logic [1:0]    mode_q;
  logic [MW-1:0] m_q;
  logic [BW-1:0] b_q, b_d;
  logic [MW-1:0] g_q;
  logic          s1_sync_q, s1_up_q, v1_q;
  logic [OW-1:0] mtr_q, mtr_d;
  logic          sync_q, up_q, vld_q;

  logic          first;
  logic [1:0]    mode_e;
  logic [MW-1:0] g_e;
  logic [PW-1:0] lvl;
  logic          up_e;
  logic [XW-1:0] prod, shifted;

  always_comb begin
    first  = (ph_q == '0);
    // Period start uses the live inputs so the first sample after reset is not stale.
    mode_e = first ? mode : mode_q;
    g_e    = first ? M : m_q;
    lvl    = '0;
    up_e   = 1'b1;
    case (mode_e)
      ModeTri: begin
        lvl  = (ph_q <= PhHalf) ? ph_q : (PhLast - ph_q) + PW'(1);
        up_e = (ph_q < PhHalf);
      end
      ModeSawUp: begin
        lvl  = ph_q >> 1;
        up_e = 1'b1;
      end
      ModeSquare: begin
        lvl  = (ph_q < PhHalf) ? PhHalf : '0;
        up_e = (ph_q < PhHalf);
      end
      default: begin
        lvl  = (PhLast - ph_q) >> 1;
        up_e = 1'b0;
      end
    endcase
    ph_d    = (ph_q == PhLast) ? '0 : ph_q + PW'(1);
    b_d     = BW'(lvl) * ScaleB;
    prod    = XW'(b_q) * XW'(g_q);
    shifted = prod >> MSH;
    mtr_d   = (shifted > Sat) ? OW'(Sat) : OW'(shifted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= '0;
      mode_q    <= '0;
      m_q       <= '0;
      b_q       <= '0;
      g_q       <= '0;
      s1_sync_q <= 1'b0;
      s1_up_q   <= 1'b0;
      v1_q      <= 1'b0;
      mtr_q     <= '0;
      sync_q    <= 1'b0;
      up_q      <= 1'b1;
      vld_q     <= 1'b0;
    end else begin
      v1_q  <= ce;
      vld_q <= v1_q;
      if (ce) begin
        ph_q <= ph_d;
        if (first) begin
          mode_q <= mode;
          m_q    <= M;
        end
        b_q       <= b_d;
        g_q       <= g_e;
        s1_sync_q <= first;
        s1_up_q   <= up_e;
      end
      if (v1_q) begin
        mtr_q  <= mtr_d;
        sync_q <= s1_sync_q;
        up_q   <= s1_up_q;
      end
    end
  end

  assign MTR  = mtr_q;
  assign vld  = vld_q;
  assign sync = sync_q;
  assign UP   = up_q;

endmodule
